eth_arb_mux: RTL and testbench

- Round-robin arbiter that shares one Ethernet frame stream among S_COUNT frame sources. Each source presents a split header (MACs + ethertype) and a payload AXI stream.
- Typical clients: ARP responder and IP TX path feeding the single frame transmitter.
- Arbitration is frame-granular: a grant is held from header acceptance until the payload beat with tlast is accepted.
- Header output is registered; payload passes through a one-deep output register.

---
 rtl/eth_arb_mux.sv | 162 ++++++++++++++++
 tb/tb_eth_arb_mux.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_arb_mux.sv
// Round-robin, frame-granular arbiter merging S_COUNT split-header Ethernet sources
// onto one header register plus a one-deep payload output register.
module eth_arb_mux #(
    parameter int S_COUNT    = 2,
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int SEL_WIDTH  = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,

    input  logic [S_COUNT-1:0]             s_eth_hdr_valid,
    output logic [S_COUNT-1:0]             s_eth_hdr_ready,
    input  logic [S_COUNT*48-1:0]          s_eth_dest_mac,
    input  logic [S_COUNT*48-1:0]          s_eth_src_mac,
    input  logic [S_COUNT*16-1:0]          s_eth_type,
    input  logic [S_COUNT*DATA_WIDTH-1:0]  s_eth_payload_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0]  s_eth_payload_axis_tkeep,
    input  logic [S_COUNT-1:0]             s_eth_payload_axis_tvalid,
    output logic [S_COUNT-1:0]             s_eth_payload_axis_tready,
    input  logic [S_COUNT-1:0]             s_eth_payload_axis_tlast,
    input  logic [S_COUNT-1:0]             s_eth_payload_axis_tuser,

    output logic                           m_eth_hdr_valid,
    input  logic                           m_eth_hdr_ready,
    output logic [47:0]                    m_eth_dest_mac,
    output logic [47:0]                    m_eth_src_mac,
    output logic [15:0]                    m_eth_type,
    output logic [DATA_WIDTH-1:0]          m_eth_payload_axis_tdata,
    output logic [KEEP_WIDTH-1:0]          m_eth_payload_axis_tkeep,
    output logic                           m_eth_payload_axis_tvalid,
    input  logic                           m_eth_payload_axis_tready,
    output logic                           m_eth_payload_axis_tlast,
    output logic                           m_eth_payload_axis_tuser,

    output logic                           busy,
    output logic [SEL_WIDTH-1:0]           grant_index
);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
    // valid never waits on ready, and data is held stable while valid is high and ready is low.

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    state_t                 state;
    logic [SEL_WIDTH-1:0]   last_grant;
    logic [SEL_WIDTH-1:0]   winner;
    logic [SEL_WIDTH-1:0]   scan_idx;
    logic                   winner_found;
    logic                   hdr_slot_free;
    logic                   hdr_take;

    logic                   in_valid;
    logic                   in_ready;
    logic                   in_hs;
    logic [DATA_WIDTH-1:0]  in_data;
    logic [KEEP_WIDTH-1:0]  in_keep;
    logic                   in_last;
    logic                   in_user;

    assign hdr_slot_free = !m_eth_hdr_valid || m_eth_hdr_ready;

    // Scan upward from the source after the last grant, wrapping, so priority rotates.
    always_comb begin
        winner       = '0;
        winner_found = 1'b0;
        scan_idx     = '0;
        for (int k = 1; k <= S_COUNT; k++) begin
            scan_idx = SEL_WIDTH'((int'(last_grant) + k) % S_COUNT);
            if (!winner_found && s_eth_hdr_valid[scan_idx]) begin
                winner       = scan_idx;
                winner_found = 1'b1;
            end
        end
    end

    assign hdr_take = rst_n && (state == IDLE) && winner_found && hdr_slot_free;

    always_comb begin
        s_eth_hdr_ready = '0;
        if (hdr_take) begin
            s_eth_hdr_ready[winner] = 1'b1;
        end
    end

    assign in_valid = s_eth_payload_axis_tvalid[grant_index];
    assign in_data  = s_eth_payload_axis_tdata[int'(grant_index)*DATA_WIDTH +: DATA_WIDTH];
    assign in_keep  = s_eth_payload_axis_tkeep[int'(grant_index)*KEEP_WIDTH +: KEEP_WIDTH];
    assign in_last  = s_eth_payload_axis_tlast[grant_index];
    assign in_user  = s_eth_payload_axis_tuser[grant_index];

    // The output register accepts a beat whenever it is empty or being drained this cycle.
    assign in_ready = rst_n && (state == PAYLOAD) &&
                      (!m_eth_payload_axis_tvalid || m_eth_payload_axis_tready);
    assign in_hs    = in_valid && in_ready;

    always_comb begin
        s_eth_payload_axis_tready = '0;
        s_eth_payload_axis_tready[grant_index] = in_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                     <= IDLE;
            last_grant                <= SEL_WIDTH'(S_COUNT - 1);
            grant_index               <= '0;
            busy                      <= 1'b0;
            m_eth_hdr_valid           <= 1'b0;
            m_eth_dest_mac            <= '0;
            m_eth_src_mac             <= '0;
            m_eth_type                <= '0;
            m_eth_payload_axis_tdata  <= '0;
            m_eth_payload_axis_tkeep  <= '0;
            m_eth_payload_axis_tvalid <= 1'b0;
            m_eth_payload_axis_tlast  <= 1'b0;
            m_eth_payload_axis_tuser  <= 1'b0;
        end else begin
            // Header register runs independently of payload progress.
            if (hdr_take) begin
                m_eth_hdr_valid <= 1'b1;
                m_eth_dest_mac  <= s_eth_dest_mac[int'(winner)*48 +: 48];
                m_eth_src_mac   <= s_eth_src_mac[int'(winner)*48 +: 48];
                m_eth_type      <= s_eth_type[int'(winner)*16 +: 16];
            end else if (m_eth_hdr_ready) begin
                m_eth_hdr_valid <= 1'b0;
            end

            if (in_hs) begin
                m_eth_payload_axis_tdata  <= in_data;
                m_eth_payload_axis_tkeep  <= in_keep;
                m_eth_payload_axis_tlast  <= in_last;
                m_eth_payload_axis_tuser  <= in_user;
                m_eth_payload_axis_tvalid <= 1'b1;
            end else if (m_eth_payload_axis_tready) begin
                m_eth_payload_axis_tvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (hdr_take) begin
                        grant_index <= winner;
                        last_grant  <= winner;
                        busy        <= 1'b1;
                        state       <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    // The last beat may still sit in the output register; arbitration resumes anyway.
                    if (in_hs && in_last) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_arb_mux.sv
// Directed bench for eth_arb_mux with three sources: expected headers and beats are queued
// by the test sequence and compared by an independent output monitor.
module tb_eth_arb_mux;

    localparam int S  = 3;
    localparam int DW = 8;
    localparam int KW = 1;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [S-1:0]      s_hdr_valid;
    logic [S-1:0]      s_hdr_ready;
    logic [47:0]       dmac_s [S];
    logic [47:0]       smac_s [S];
    logic [15:0]       type_s [S];
    logic [DW-1:0]     tdata_s [S];
    logic [S*48-1:0]   s_dest_flat;
    logic [S*48-1:0]   s_src_flat;
    logic [S*16-1:0]   s_type_flat;
    logic [S*DW-1:0]   s_tdata_flat;
    logic [S*KW-1:0]   s_tkeep;
    logic [S-1:0]      s_tvalid;
    logic [S-1:0]      s_tready;
    logic [S-1:0]      s_tlast;
    logic [S-1:0]      s_tuser;

    logic              m_hdr_valid;
    logic              m_hdr_ready;
    logic [47:0]       m_dest;
    logic [47:0]       m_src;
    logic [15:0]       m_type;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;
    logic              m_tuser;
    logic              busy;
    logic [SW-1:0]     grant_index;

    assign s_dest_flat  = {dmac_s[2], dmac_s[1], dmac_s[0]};
    assign s_src_flat   = {smac_s[2], smac_s[1], smac_s[0]};
    assign s_type_flat  = {type_s[2], type_s[1], type_s[0]};
    assign s_tdata_flat = {tdata_s[2], tdata_s[1], tdata_s[0]};

    eth_arb_mux #(.S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .SEL_WIDTH(SW)) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .s_eth_hdr_valid           (s_hdr_valid),
        .s_eth_hdr_ready           (s_hdr_ready),
        .s_eth_dest_mac            (s_dest_flat),
        .s_eth_src_mac             (s_src_flat),
        .s_eth_type                (s_type_flat),
        .s_eth_payload_axis_tdata  (s_tdata_flat),
        .s_eth_payload_axis_tkeep  (s_tkeep),
        .s_eth_payload_axis_tvalid (s_tvalid),
        .s_eth_payload_axis_tready (s_tready),
        .s_eth_payload_axis_tlast  (s_tlast),
        .s_eth_payload_axis_tuser  (s_tuser),
        .m_eth_hdr_valid           (m_hdr_valid),
        .m_eth_hdr_ready           (m_hdr_ready),
        .m_eth_dest_mac            (m_dest),
        .m_eth_src_mac             (m_src),
        .m_eth_type                (m_type),
        .m_eth_payload_axis_tdata  (m_tdata),
        .m_eth_payload_axis_tkeep  (m_tkeep),
        .m_eth_payload_axis_tvalid (m_tvalid),
        .m_eth_payload_axis_tready (m_tready),
        .m_eth_payload_axis_tlast  (m_tlast),
        .m_eth_payload_axis_tuser  (m_tuser),
        .busy                      (busy),
        .grant_index               (grant_index)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // ---------------- scoreboard state ----------------
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [113:0]  exp_hdr_q[$];   // {src, dest, src_mac, type}
    logic [10:0]   exp_q[$];       // {tuser, tlast, tkeep, tdata}

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_accept(input int src, input bit is_hdr);
        int   n;
        logic acc;
        n = 0;
        do begin
            @(negedge clk);
            acc = is_hdr ? s_hdr_ready[src] : s_tready[src];
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: src %0d hdr %0d not accepted within %0d cycles", src, is_hdr, n);
        end
    endtask

    task automatic set_hdr(input int src, input logic [47:0] dm, input logic [47:0] sm,
                           input logic [15:0] et);
        dmac_s[src] = dm;
        smac_s[src] = sm;
        type_s[src] = et;
        s_hdr_valid[src] = 1'b1;
    endtask

    task automatic set_beat(input int src, input logic [7:0] d, input logic last, input logic user);
        tdata_s[src]  = d;
        s_tkeep[src]  = 1'b1;
        s_tlast[src]  = last;
        s_tuser[src]  = user;
        s_tvalid[src] = 1'b1;
    endtask

    task automatic clear_beat(input int src);
        s_tvalid[src] = 1'b0;
        s_tlast[src]  = 1'b0;
        s_tuser[src]  = 1'b0;
    endtask

    task automatic send_frame(input int src, input logic [47:0] dm, input logic [47:0] sm,
                              input logic [15:0] et, input int nb, input logic [31:0] data,
                              input logic user_last);
        set_hdr(src, dm, sm, et);
        wait_accept(src, 1'b1);
        s_hdr_valid[src] = 1'b0;
        for (int j = 0; j < nb; j++) begin
            set_beat(src, data[j*8 +: 8], j == nb - 1, (j == nb - 1) ? user_last : 1'b0);
            wait_accept(src, 1'b0);
        end
        clear_beat(src);
    endtask

    task automatic expect_frame(input int src, input logic [47:0] dm, input logic [47:0] sm,
                                input logic [15:0] et, input int nb, input logic [31:0] data,
                                input logic user_last);
        exp_hdr_q.push_back({2'(src), dm, sm, et});
        for (int j = 0; j < nb; j++) begin
            exp_q.push_back({(j == nb - 1) ? user_last : 1'b0, j == nb - 1, 1'b1, data[j*8 +: 8]});
        end
    endtask

    // ---------------- output monitor ----------------
    logic consec_chk = 1'b0;
    logic have_prev  = 1'b0;
    int   prev_out   = 0;

    always @(negedge clk) begin
        if (rst_n && m_hdr_valid && m_hdr_ready) begin
            if (exp_hdr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL hdr_unexpected: got src %0d type %0h with nothing expected", grant_index, m_type);
            end else begin
                check("hdr_out", {grant_index, m_dest, m_src, m_type}, exp_hdr_q.pop_front());
            end
        end
        if (rst_n && m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL beat_unexpected: got data %0h with nothing expected", m_tdata);
            end else begin
                check("beat_out", {m_tuser, m_tlast, m_tkeep, m_tdata}, exp_q.pop_front());
            end
            if (consec_chk && have_prev) check("beat_spacing", cyc - prev_out, 1);
            prev_out  = cyc;
            have_prev = !m_tlast;
        end
    end

    // ---------------- per-cycle protocol rules ----------------
    logic       busy_exp   = 1'b0;
    logic       hdr_hs_d   = 1'b0;
    logic       beat_hs_d  = 1'b0;
    logic [1:0] hs_src_d   = '0;
    logic       gap_chk    = 1'b0;
    logic       tlast_seen = 1'b0;
    int         tlast_edge = 0;
    int         s_hdr_edge = 0;
    logic       s_hdr_coinc = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_exp  = 1'b0;
            hdr_hs_d  = 1'b0;
            beat_hs_d = 1'b0;
        end else begin
            check("busy", busy, busy_exp);
            if (hdr_hs_d) begin
                check("hdr_latency", m_hdr_valid, 1);
                check("grant_index", grant_index, hs_src_d);
            end
            if (beat_hs_d) check("beat_latency", m_tvalid, 1);
            check("hdr_ready_onehot", $countones(s_hdr_ready) <= 1, 1);
            if (|s_hdr_ready) check("hdr_ready_slot", (!m_hdr_valid || m_hdr_ready) && !busy, 1);
            for (int i = 0; i < S; i++) begin
                check($sformatf("payload_ready_s%0d", i), s_tready[i],
                      busy && (grant_index == SW'(i)) && (!m_tvalid || m_tready));
            end

            hdr_hs_d  = |(s_hdr_valid & s_hdr_ready);
            beat_hs_d = |(s_tvalid & s_tready);
            for (int i = 0; i < S; i++) begin
                if (s_hdr_valid[i] && s_hdr_ready[i]) hs_src_d = 2'(i);
            end
            if (hdr_hs_d) begin
                busy_exp = 1'b1;
                if (gap_chk && tlast_seen) check("frame_gap", cyc + 1, tlast_edge + 1);
                s_hdr_edge  = cyc + 1;
                s_hdr_coinc = m_hdr_valid && m_hdr_ready;
            end
            if (|(s_tvalid & s_tready & s_tlast)) begin
                busy_exp   = 1'b0;
                tlast_seen = 1'b1;
                tlast_edge = cyc + 1;
            end
        end
    end

    // ---------------- test sequence ----------------
    int release_edge;

    initial begin
        s_hdr_valid = '0;
        s_tkeep     = '0;
        s_tvalid    = '0;
        s_tlast     = '0;
        s_tuser     = '0;
        for (int i = 0; i < S; i++) begin
            dmac_s[i]  = '0;
            smac_s[i]  = '0;
            type_s[i]  = '0;
            tdata_s[i] = '0;
        end
        m_hdr_ready = 1'b1;
        m_tready    = 1'b1;
        rst_n       = 1'b0;
        s_hdr_valid[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hdr_valid", m_hdr_valid, 0);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_index, 0);
        check("rst_hdr_ready", s_hdr_ready, 0);
        check("rst_dest", m_dest, 0);
        s_hdr_valid = '0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single source, three beats, sinks always ready
        consec_chk = 1'b1;
        expect_frame(0, 48'h0A0B0C0D0E0F, 48'h020000000001, 16'h0806, 3, 32'h00332211, 1'b0);
        send_frame(0, 48'h0A0B0C0D0E0F, 48'h020000000001, 16'h0806, 3, 32'h00332211, 1'b0);
        check("t1_busy_after", busy, 0);
        check("t1_grant", grant_index, 0);
        repeat (3) @(posedge clk);
        #1;
        consec_chk = 1'b0;

        // two sources from reset, two frames each: grant order 0,1,0,1
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        gap_chk    = 1'b1;
        tlast_seen = 1'b0;
        expect_frame(0, 48'h000000000A01, 48'h0000000000B0, 16'h0800, 2, 32'h0000A2A1, 1'b0);
        expect_frame(1, 48'h000000000A11, 48'h0000000000B1, 16'h0801, 2, 32'h0000B2B1, 1'b0);
        expect_frame(0, 48'h000000000A02, 48'h0000000000B0, 16'h0802, 2, 32'h0000C2C1, 1'b0);
        expect_frame(1, 48'h000000000A12, 48'h0000000000B1, 16'h0803, 2, 32'h0000D2D1, 1'b0);
        fork
            begin
                send_frame(0, 48'h000000000A01, 48'h0000000000B0, 16'h0800, 2, 32'h0000A2A1, 1'b0);
                send_frame(0, 48'h000000000A02, 48'h0000000000B0, 16'h0802, 2, 32'h0000C2C1, 1'b0);
            end
            begin
                send_frame(1, 48'h000000000A11, 48'h0000000000B1, 16'h0801, 2, 32'h0000B2B1, 1'b0);
                send_frame(1, 48'h000000000A12, 48'h0000000000B1, 16'h0803, 2, 32'h0000D2D1, 1'b0);
            end
        join
        gap_chk = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // output backpressure 1,0,0,1 during a four-beat frame
        expect_frame(0, 48'h111111111111, 48'h222222222222, 16'h86DD, 4, 32'h44332211, 1'b0);
        fork
            send_frame(0, 48'h111111111111, 48'h222222222222, 16'h86DD, 4, 32'h44332211, 1'b0);
            begin
                repeat (2) @(posedge clk);
                #1 m_tready = 1'b1;
                @(posedge clk);
                #1 m_tready = 1'b0;
                @(posedge clk);
                #1 m_tready = 1'b0;
                @(posedge clk);
                #1 m_tready = 1'b1;
            end
        join
        m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // header output stalled: source 1 waits for the header slot
        m_hdr_ready = 1'b0;
        expect_frame(0, 48'h0000000000AA, 48'h0000000000A0, 16'h0800, 2, 32'h00005251, 1'b0);
        expect_frame(1, 48'h0000000000BB, 48'h0000000000B0, 16'h0806, 1, 32'h00000061, 1'b0);
        fork
            send_frame(0, 48'h0000000000AA, 48'h0000000000A0, 16'h0800, 2, 32'h00005251, 1'b0);
            begin
                @(posedge clk);
                #1;
                send_frame(1, 48'h0000000000BB, 48'h0000000000B0, 16'h0806, 1, 32'h00000061, 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                release_edge = cyc + 1;
                m_hdr_ready  = 1'b1;
            end
        join
        check("t4_accept_edge", s_hdr_edge, release_edge);
        check("t4_accept_with_take", s_hdr_coinc, 1);
        repeat (3) @(posedge clk);
        #1;

        // reset while beat 2 of 4 sits in the output register
        exp_hdr_q.push_back({2'd0, 48'h0000000000CC, 48'h0000000000C0, 16'h0800});
        exp_q.push_back({1'b0, 1'b0, 1'b1, 8'hE1});
        set_hdr(0, 48'h0000000000CC, 48'h0000000000C0, 16'h0800);
        wait_accept(0, 1'b1);
        s_hdr_valid[0] = 1'b0;
        set_beat(0, 8'hE1, 1'b0, 1'b0);
        wait_accept(0, 1'b0);
        set_beat(0, 8'hE2, 1'b0, 1'b0);
        wait_accept(0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t5_tvalid", m_tvalid, 0);
        check("t5_tdata", m_tdata, 0);
        check("t5_busy", busy, 0);
        check("t5_hdr_valid", m_hdr_valid, 0);
        check("t5_tready", s_tready, 0);
        clear_beat(0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_frame(0, 48'h0000000000D0, 48'h0000000000D1, 16'h0800, 3, 32'h00F3F2F1, 1'b0);
        expect_frame(1, 48'h0000000000D8, 48'h0000000000D9, 16'h0806, 2, 32'h00007271, 1'b0);
        fork
            send_frame(0, 48'h0000000000D0, 48'h0000000000D1, 16'h0800, 3, 32'h00F3F2F1, 1'b0);
            send_frame(1, 48'h0000000000D8, 48'h0000000000D9, 16'h0806, 2, 32'h00007271, 1'b0);
        join
        repeat (3) @(posedge clk);
        #1;

        // source 2 alone with tuser on the last beat; sources 0/1 offer payload without a header
        set_beat(0, 8'h99, 1'b0, 1'b0);
        set_beat(1, 8'h98, 1'b1, 1'b1);
        expect_frame(2, 48'hFFFFFFFFFFFF, 48'h023456789ABC, 16'h0806, 3, 32'h00C3C2C1, 1'b1);
        send_frame(2, 48'hFFFFFFFFFFFF, 48'h023456789ABC, 16'h0806, 3, 32'h00C3C2C1, 1'b1);
        check("t6_grant", grant_index, 2);
        repeat (2) @(posedge clk);
        #1;
        clear_beat(0);
        clear_beat(1);

        for (int n = 0; n < 100 && (exp_q.size() != 0 || exp_hdr_q.size() != 0); n++) begin
            @(posedge clk);
        end
        #1;
        check("hdr_q_drained", exp_hdr_q.size(), 0);
        check("beat_q_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
